// File: rtl/mips_rf_pkg.sv
// Shared register-file write types and constants for the writeback arbiter.
// The FIFO payload is the rf_wr_t struct; widths must match the arbiter's ADDR_W/DATA_W.
package mips_rf_pkg;

   localparam int NUM_REGS  = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] adrs;
      logic [RF_DATA_W-1:0] data;
   } rf_wr_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [RF_ADDR_W-1:0] adrs);
      return NUM_REGS'(1) << adrs;
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Generic count-based FIFO; push lands in storage at the edge, head readable next cycle.
// Backpressure: full from the registered count, so a pop never frees a slot in the same cycle.
module rf_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 37
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_vld,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop_rdy,
   output logic [W-1:0]             head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [W-1:0]     mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign head_dat = mem_q[rd_ptr_q];

   assign push_ok = push_vld && !full;
   assign pop_ok  = pop_rdy && !empty;

   // DEPTH is a power of two, so pointer increments wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole register-file writer: pipeline writes pass through combinationally, long-latency results drain from a FIFO (>=1 cycle).
// Backpressure: lu_ready drops when the FIFO is full; the pipeline is never stalled and always wins the port.
module regfile_write_arbiter
   import mips_rf_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DATA_W = RF_DATA_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 pipe_we,
   input  logic [ADDR_W-1:0]    pipe_adrs,
   input  logic [DATA_W-1:0]    pipe_data,
   input  logic                 lu_issue,
   input  logic [ADDR_W-1:0]    lu_issue_adrs,
   input  logic                 lu_valid,
   input  logic [ADDR_W-1:0]    lu_adrs,
   input  logic [DATA_W-1:0]    lu_data,
   output logic                 lu_ready,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_w_adrs,
   output logic [DATA_W-1:0]    rf_w_data,
   output logic [NUM_REGS-1:0]  pending_mask,
   output logic                 proto_err
);

   rf_wr_t                  push_dat;
   rf_wr_t                  head_dat;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    pipe_act;
   logic                    port_free;
   logic                    drain;
   logic                    push_vld;

   logic [NUM_REGS-1:0]     pending_q, pending_d;
   logic                    proto_err_q, proto_err_d;
   logic [NUM_REGS-1:0]     set_mask;
   logic [NUM_REGS-1:0]     clr_mask;
   logic                    issue_err;
   logic                    pipe_err;
   logic                    lu_err;

   // Gating with reset_n keeps the write port quiet while reset is held.
   assign pipe_act  = reset_n && pipe_we && (pipe_adrs != REG_ZERO);
   assign port_free = !pipe_act;
   assign drain     = port_free && !fifo_empty;

   assign lu_ready  = !fifo_full;
   // r0 results complete the handshake but are never stored.
   assign push_vld  = lu_valid && (lu_adrs != REG_ZERO);
   assign push_dat  = '{adrs: lu_adrs, data: lu_data};

   rf_wb_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(rf_wr_t))
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_rdy  (port_free),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_comb begin
      rf_we     = 1'b0;
      rf_w_adrs = '0;
      rf_w_data = '0;
      if (pipe_act) begin
         rf_we     = 1'b1;
         rf_w_adrs = pipe_adrs;
         rf_w_data = pipe_data;
      end else if (drain) begin
         rf_we     = 1'b1;
         rf_w_adrs = head_dat.adrs;
         rf_w_data = head_dat.data;
      end
   end

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (lu_issue && (lu_issue_adrs != REG_ZERO)) begin
         set_mask = reg_onehot(lu_issue_adrs);
      end
      if (drain) begin
         clr_mask = reg_onehot(head_dat.adrs);
      end
      // Set applied after clear so a same-cycle reissue keeps the bit.
      pending_d = (pending_q & ~clr_mask) | set_mask;
   end

   always_comb begin
      issue_err   = |(set_mask & pending_q & ~clr_mask);
      pipe_err    = pipe_act && pending_q[pipe_adrs];
      lu_err      = lu_valid && !pending_q[lu_adrs];
      proto_err_d = proto_err_q || issue_err || pipe_err || lu_err;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign pending_mask = pending_q;
   assign proto_err    = proto_err_q;

endmodule
